fft_bank_sched: RTL and testbench

Ping-pong bank scheduler for the FFT datapath. It owns two N-point sample banks and sequences three activities over them: loading the input stream, issuing butterflies to the existing address LUT and butterfly datapath, and draining results with a proper out_stall handshake. Frame k+1 loads into one bank while frame k is computed and drained from the other. It replaces the single-buffer control flow, which cannot accept input during compute.

---
 rtl/fft_sched_pkg.sv | 36 +++
 rtl/fft_bank_state.sv | 41 ++++
 rtl/fft_bank_sched.sv | 213 +++++++++++++++++++++
 tb/tb_fft_bank_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and size helpers for the ping-pong FFT bank scheduler.
package fft_sched_pkg;

  // Lifecycle of one sample bank.
  typedef enum logic [2:0] {
    BK_FREE,
    BK_FILL,
    BK_READY,
    BK_COMPUTE,
    BK_DRAIN
  } bank_state_t;

  // Engine sequencing: pick up a ready bank, run all butterflies, then drain it.
  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_COMPUTE,
    ENG_DRAIN
  } eng_state_t;

  // Width of the stage index sent to the address LUT (covers LOG2N up to 8).
  localparam int STAGE_W = 3;

  // Width of the completed-frame counter.
  localparam int FRAME_CNT_W = 16;

  // Number of FFT points for a given log2 size.
  function automatic int n_points(input int log2n);
    return 1 << log2n;
  endfunction

  // Butterflies per stage for a given log2 size.
  function automatic int n_bfly(input int log2n);
    return 1 << (log2n - 1);
  endfunction

endpackage

// File: rtl/fft_bank_state.sv
// Per-bank lifecycle tracker: FREE -> FILL -> READY -> COMPUTE -> DRAIN -> FREE.
// Each transition fires only on the strobe that belongs to the current state,
// so stray strobes for other phases are ignored.
module fft_bank_state
  import fft_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_fill,
  input  logic        fill_done,
  input  logic        start_compute,
  input  logic        compute_done,
  input  logic        drain_done,
  output bank_state_t state
);

  bank_state_t state_next;

  // Choose the next lifecycle state from the strobe matching the current state.
  always_comb begin
    state_next = state;
    case (state)
      BK_FREE:    if (start_fill)    state_next = BK_FILL;
      BK_FILL:    if (fill_done)     state_next = BK_READY;
      BK_READY:   if (start_compute) state_next = BK_COMPUTE;
      BK_COMPUTE: if (compute_done)  state_next = BK_DRAIN;
      BK_DRAIN:   if (drain_done)    state_next = BK_FREE;
      default:                       state_next = BK_FREE;
    endcase
  end

  // Hold the bank state; reset abandons whatever frame the bank held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BK_FREE;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/fft_bank_sched.sv
// Ping-pong bank scheduler for the FFT datapath. The loader fills one bank
// while the engine computes and drains the other; the two run independently
// and only meet through the registered per-bank states.
module fft_bank_sched
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = 4  // legal range 3..6
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_push,
  output logic                   in_stall,
  output logic                   in_we,
  output logic                   in_bank,
  output logic [LOG2N-1:0]       in_addr,
  output logic                   eng_valid,
  output logic                   eng_bank,
  output logic [STAGE_W-1:0]     eng_stage,
  output logic [LOG2N-2:0]       eng_bfly,
  output logic                   out_push,
  input  logic                   out_stall,
  output logic [LOG2N-1:0]       out_addr,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int N  = n_points(LOG2N);
  localparam int NB = n_bfly(LOG2N);

  localparam logic [LOG2N-1:0]   ADDR_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0]   BFLY_LAST  = (LOG2N - 1)'(NB - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  bank_state_t bank_st [2];

  logic       ld_sel;
  logic       eng_sel;
  eng_state_t eng_state;
  eng_state_t eng_next;

  logic accept;
  logic ld_last;
  logic ready_seen;
  logic bfly_last;
  logic drain_last;
  logic xfer;

  logic eng_start;
  logic comp_done;
  logic drain_done;

  logic [1:0] start_fill_v;
  logic [1:0] fill_done_v;
  logic [1:0] start_compute_v;
  logic [1:0] compute_done_v;
  logic [1:0] drain_done_v;

  // ---------------------------------------------------------------------------
  // Loader: stalls unless its bank can still take samples.
  // ---------------------------------------------------------------------------
  assign in_bank  = ld_sel;
  assign in_stall = !((bank_st[ld_sel] == BK_FREE) || (bank_st[ld_sel] == BK_FILL));
  assign in_we    = in_push & ~in_stall;
  assign accept   = in_we;
  assign ld_last  = (in_addr == ADDR_LAST);

  // Advance the write index; the last sample of a frame hands over to the other bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_sel  <= 1'b0;
      in_addr <= '0;
    end else if (accept) begin
      if (ld_last) begin
        in_addr <= '0;
        ld_sel  <= ~ld_sel;
      end else begin
        in_addr <= in_addr + 1'b1;
      end
    end
  end

  // Sticky overrun: a rejected push sets it, and that set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (in_push && in_stall) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine FSM. IDLE only looks at the registered bank state, so a bank that
  // turns READY at an edge is picked up one cycle later.
  // ---------------------------------------------------------------------------
  assign eng_bank   = eng_sel;
  assign ready_seen = (bank_st[eng_sel] == BK_READY);
  assign bfly_last  = (eng_stage == STAGE_LAST) && (eng_bfly == BFLY_LAST);
  assign drain_last = (out_addr == ADDR_LAST);
  // Only combinational path from out_stall: qualifies the drain transfer.
  assign xfer       = (eng_state == ENG_DRAIN) && !out_stall;

  // Register the engine state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_state <= ENG_IDLE;
    end else begin
      eng_state <= eng_next;
    end
  end

  // Sequence IDLE -> COMPUTE -> DRAIN -> IDLE.
  always_comb begin
    eng_next = eng_state;
    case (eng_state)
      ENG_IDLE:    if (ready_seen)          eng_next = ENG_COMPUTE;
      ENG_COMPUTE: if (bfly_last)           eng_next = ENG_DRAIN;
      ENG_DRAIN:   if (xfer && drain_last)  eng_next = ENG_IDLE;
      default:                              eng_next = ENG_IDLE;
    endcase
  end

  // Decode engine outputs and bank event strobes from the current state.
  always_comb begin
    eng_valid  = 1'b0;
    out_push   = 1'b0;
    eng_start  = 1'b0;
    comp_done  = 1'b0;
    drain_done = 1'b0;
    case (eng_state)
      ENG_IDLE: begin
        eng_start = ready_seen;
      end
      ENG_COMPUTE: begin
        // The datapath reads and writes back in one cycle, so no bubbles.
        eng_valid = 1'b1;
        comp_done = bfly_last;
      end
      ENG_DRAIN: begin
        out_push   = 1'b1;
        drain_done = xfer && drain_last;
      end
      default: ;
    endcase
  end

  // Butterfly/stage and drain counters; they read as 0 whenever the engine is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_sel   <= 1'b0;
      eng_stage <= '0;
      eng_bfly  <= '0;
      out_addr  <= '0;
      frame_cnt <= '0;
    end else begin
      case (eng_state)
        ENG_COMPUTE: begin
          if (eng_bfly == BFLY_LAST) begin
            eng_bfly  <= '0;
            eng_stage <= bfly_last ? '0 : eng_stage + 1'b1;
          end else begin
            eng_bfly <= eng_bfly + 1'b1;
          end
        end
        ENG_DRAIN: begin
          if (xfer) begin
            if (drain_last) begin
              out_addr  <= '0;
              eng_sel   <= ~eng_sel;
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              out_addr <= out_addr + 1'b1;
            end
          end
        end
        default: begin
          eng_stage <= '0;
          eng_bfly  <= '0;
          out_addr  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Two bank trackers; each strobe is steered to the bank its owner points at.
  // Loader and engine updates can land on different banks in the same cycle.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign start_fill_v[gi]    = accept && (ld_sel == 1'(gi)) && (bank_st[gi] == BK_FREE);
      assign fill_done_v[gi]     = accept && ld_last && (ld_sel == 1'(gi));
      assign start_compute_v[gi] = eng_start  && (eng_sel == 1'(gi));
      assign compute_done_v[gi]  = comp_done  && (eng_sel == 1'(gi));
      assign drain_done_v[gi]    = drain_done && (eng_sel == 1'(gi));

      fft_bank_state u_bank (
        .clk           (clk),
        .reset         (reset),
        .start_fill    (start_fill_v[gi]),
        .fill_done     (fill_done_v[gi]),
        .start_compute (start_compute_v[gi]),
        .compute_done  (compute_done_v[gi]),
        .drain_done    (drain_done_v[gi]),
        .state         (bank_st[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fft_bank_sched.sv
// Directed bench for fft_bank_sched: main instance at LOG2N=4, plus LOG2N=3
// and LOG2N=6 instances for the size extremes. Cycle c is the cycle whose
// negedge the loop is at; inputs are driven and outputs sampled there.
`timescale 1ns/1ps
module tb_fft_bank_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  // LOG2N = 4 instance
  logic        in_push, in_stall, in_we, in_bank;
  logic [3:0]  in_addr;
  logic        eng_valid, eng_bank;
  logic [2:0]  eng_stage;
  logic [2:0]  eng_bfly;
  logic        out_push, out_stall;
  logic [3:0]  out_addr;
  logic [15:0] frame_cnt;
  logic        overrun, overrun_clr;

  // LOG2N = 3 instance
  logic        in_push_s, in_stall_s, in_we_s, in_bank_s;
  logic [2:0]  in_addr_s;
  logic        eng_valid_s, eng_bank_s;
  logic [2:0]  eng_stage_s;
  logic [1:0]  eng_bfly_s;
  logic        out_push_s, out_stall_s;
  logic [2:0]  out_addr_s;
  logic [15:0] frame_cnt_s;
  logic        overrun_s, overrun_clr_s;

  // LOG2N = 6 instance
  logic        in_push_l, in_stall_l, in_we_l, in_bank_l;
  logic [5:0]  in_addr_l;
  logic        eng_valid_l, eng_bank_l;
  logic [2:0]  eng_stage_l;
  logic [4:0]  eng_bfly_l;
  logic        out_push_l, out_stall_l;
  logic [5:0]  out_addr_l;
  logic [15:0] frame_cnt_l;
  logic        overrun_l, overrun_clr_l;

  fft_bank_sched #(.LOG2N(4)) dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_stall(in_stall), .in_we(in_we),
    .in_bank(in_bank), .in_addr(in_addr), .eng_valid(eng_valid), .eng_bank(eng_bank),
    .eng_stage(eng_stage), .eng_bfly(eng_bfly), .out_push(out_push), .out_stall(out_stall),
    .out_addr(out_addr), .frame_cnt(frame_cnt), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  fft_bank_sched #(.LOG2N(3)) dut_s (
    .clk(clk), .reset(reset), .in_push(in_push_s), .in_stall(in_stall_s), .in_we(in_we_s),
    .in_bank(in_bank_s), .in_addr(in_addr_s), .eng_valid(eng_valid_s), .eng_bank(eng_bank_s),
    .eng_stage(eng_stage_s), .eng_bfly(eng_bfly_s), .out_push(out_push_s), .out_stall(out_stall_s),
    .out_addr(out_addr_s), .frame_cnt(frame_cnt_s), .overrun(overrun_s), .overrun_clr(overrun_clr_s)
  );

  fft_bank_sched #(.LOG2N(6)) dut_l (
    .clk(clk), .reset(reset), .in_push(in_push_l), .in_stall(in_stall_l), .in_we(in_we_l),
    .in_bank(in_bank_l), .in_addr(in_addr_l), .eng_valid(eng_valid_l), .eng_bank(eng_bank_l),
    .eng_stage(eng_stage_l), .eng_bfly(eng_bfly_l), .out_push(out_push_l), .out_stall(out_stall_l),
    .out_addr(out_addr_l), .frame_cnt(frame_cnt_l), .overrun(overrun_l), .overrun_clr(overrun_clr_l)
  );

  task automatic idle_inputs();
    in_push   = 1'b0; out_stall   = 1'b0; overrun_clr   = 1'b0;
    in_push_s = 1'b0; out_stall_s = 1'b0; overrun_clr_s = 1'b0;
    in_push_l = 1'b0; out_stall_l = 1'b0; overrun_clr_l = 1'b0;
  endtask

  // Returns at a negedge with reset just released; that cycle is cycle 0.
  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] obs;
    do_reset();
    obs = {in_stall, in_we, in_bank, in_addr, eng_valid, eng_bank, eng_stage, eng_bfly,
           out_push, out_addr, frame_cnt, overrun};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_n4 outputs=%h want 0", obs);
    end
    obs = {in_stall_s, in_we_s, in_bank_s, in_addr_s, eng_valid_s, eng_bank_s, eng_stage_s,
           eng_bfly_s, out_push_s, out_addr_s, frame_cnt_s, overrun_s};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_n3 outputs=%h want 0", obs);
    end
    obs = {in_stall_l, in_we_l, in_bank_l, in_addr_l, eng_valid_l, eng_bank_l, eng_stage_l,
           eng_bfly_l, out_push_l, out_addr_l, frame_cnt_l, overrun_l};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_n6 outputs=%h want 0", obs);
    end
  endtask

  // Expects to be entered at cycle 0 right after reset release.
  task automatic test_single_frame(input string tag);
    logic exp_v, exp_p;
    for (int c = 0; c <= 66; c++) begin
      in_push = (c < 16);
      if (c < 16) begin
        total++;
        if (in_addr !== 4'(c) || in_bank !== 1'b0 || in_stall !== 1'b0) begin
          bad++;
          $display("FAIL %s load c=%0d addr=%0d bank=%0d stall=%0d want addr=%0d bank=0 stall=0",
                   tag, c, in_addr, in_bank, in_stall, c);
        end
      end
      exp_v = (c >= 17 && c <= 48);
      total++;
      if (eng_valid !== exp_v) begin
        bad++;
        $display("FAIL %s eng_valid c=%0d got=%0d want=%0d", tag, c, eng_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (eng_stage !== 3'((c - 17) / 8) || eng_bfly !== 3'((c - 17) % 8) || eng_bank !== 1'b0) begin
          bad++;
          $display("FAIL %s bfly c=%0d stage=%0d bfly=%0d bank=%0d want stage=%0d bfly=%0d bank=0",
                   tag, c, eng_stage, eng_bfly, eng_bank, (c - 17) / 8, (c - 17) % 8);
        end
      end
      exp_p = (c >= 49 && c <= 64);
      total++;
      if (out_push !== exp_p) begin
        bad++;
        $display("FAIL %s out_push c=%0d got=%0d want=%0d", tag, c, out_push, exp_p);
      end
      if (exp_p) begin
        total++;
        if (out_addr !== 4'(c - 49)) begin
          bad++;
          $display("FAIL %s out_addr c=%0d got=%0d want=%0d", tag, c, out_addr, c - 49);
        end
      end
      @(negedge clk);
    end
    in_push = 1'b0;
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL %s frame_cnt got=%0d want=1", tag, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 70; c++) begin
      in_push = 1'b1;
      #1;
      if (c >= 16 && c <= 31) begin
        total++;
        if (in_bank !== 1'b1 || in_addr !== 4'(c - 16) || in_we !== 1'b1) begin
          bad++;
          $display("FAIL b2b bank1_load c=%0d bank=%0d addr=%0d we=%0d want bank=1 addr=%0d we=1",
                   c, in_bank, in_addr, in_we, c - 16);
        end
      end
      if (c >= 32 && c <= 64) begin
        total++;
        if (in_stall !== 1'b1 || in_we !== 1'b0) begin
          bad++;
          $display("FAIL b2b stall c=%0d stall=%0d we=%0d want stall=1 we=0", c, in_stall, in_we);
        end
      end
      if (c >= 65) begin
        total++;
        if (in_stall !== 1'b0 || in_bank !== 1'b0 || in_addr !== 4'(c - 65)) begin
          bad++;
          $display("FAIL b2b resume c=%0d stall=%0d bank=%0d addr=%0d want stall=0 bank=0 addr=%0d",
                   c, in_stall, in_bank, in_addr, c - 65);
        end
      end
      if (c == 65) begin
        total++;
        if (eng_valid !== 1'b0 || frame_cnt !== 16'd1) begin
          bad++;
          $display("FAIL b2b idle_detect valid=%0d frames=%0d want valid=0 frames=1", eng_valid, frame_cnt);
        end
      end
      if (c == 66) begin
        total++;
        if (eng_valid !== 1'b1 || eng_bank !== 1'b1 || eng_stage !== 3'd0 || eng_bfly !== 3'd0) begin
          bad++;
          $display("FAIL b2b second_compute valid=%0d bank=%0d stage=%0d bfly=%0d want 1 1 0 0",
                   eng_valid, eng_bank, eng_stage, eng_bfly);
        end
      end
      @(negedge clk);
    end
    in_push = 1'b0;
  endtask

  task automatic test_out_stall();
    int exp_a;
    do_reset();
    for (int c = 0; c <= 72; c++) begin
      in_push   = (c < 16);
      out_stall = (c >= 52 && c <= 56);
      if (c >= 49 && c <= 69) begin
        exp_a = (c < 52) ? c - 49 : ((c <= 57) ? 3 : c - 54);
        total++;
        if (out_push !== 1'b1 || out_addr !== 4'(exp_a)) begin
          bad++;
          $display("FAIL stall drain c=%0d push=%0d addr=%0d want push=1 addr=%0d", c, out_push, out_addr, exp_a);
        end
      end
      if (c == 69 || c == 70) begin
        total++;
        if (frame_cnt !== 16'(c - 69) || out_push !== (c == 69)) begin
          bad++;
          $display("FAIL stall end c=%0d frames=%0d push=%0d want frames=%0d push=%0d",
                   c, frame_cnt, out_push, c - 69, c == 69);
        end
      end
      @(negedge clk);
    end
    in_push   = 1'b0;
    out_stall = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      case (c)
        32: begin
          total++;
          if (in_stall !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr pre stall=%0d overrun=%0d want stall=1 overrun=0", in_stall, overrun);
          end
          in_push = 1'b1;
          #1;
          total++;
          if (in_we !== 1'b0) begin
            bad++;
            $display("FAIL ovr no_write we=%0d want 0", in_we);
          end
        end
        33: begin
          total++;
          if (overrun !== 1'b1 || in_addr !== 4'd0 || in_bank !== 1'b0) begin
            bad++;
            $display("FAIL ovr set overrun=%0d addr=%0d bank=%0d want 1 0 0", overrun, in_addr, in_bank);
          end
          in_push     = 1'b1;
          overrun_clr = 1'b1;
        end
        34: begin
          total++;
          if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr set_wins overrun=%0d want 1", overrun);
          end
          in_push     = 1'b0;
          overrun_clr = 1'b1;
        end
        35: begin
          total++;
          if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr clear overrun=%0d want 0", overrun);
          end
          overrun_clr = 1'b0;
        end
        default: in_push = (c < 32);
      endcase
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [47:0] obs;
    do_reset();
    for (int c = 0; c < 37; c++) begin
      in_push = (c < 16);
      @(negedge clk);
    end
    in_push = 1'b0;
    total++;
    if (eng_valid !== 1'b1 || eng_stage !== 3'd2 || eng_bfly !== 3'd4) begin
      bad++;
      $display("FAIL rstmid position valid=%0d stage=%0d bfly=%0d want 1 2 4", eng_valid, eng_stage, eng_bfly);
    end
    reset = 1'b1;
    #1;
    obs = {in_stall, in_we, in_bank, in_addr, eng_valid, eng_bank, eng_stage, eng_bfly,
           out_push, out_addr, frame_cnt, overrun};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rstmid async outputs=%h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    test_single_frame("rstmid_frame");
  endtask

  task automatic test_log2n3();
    int first, vcnt, dcnt, smax;
    first = -1; vcnt = 0; dcnt = 0; smax = 0;
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      in_push_s = (c < 8);
      if (eng_valid_s === 1'b1) begin
        if (first < 0) first = c;
        vcnt++;
        if (int'(eng_stage_s) > smax) smax = int'(eng_stage_s);
      end
      if (out_push_s === 1'b1) dcnt++;
      @(negedge clk);
    end
    in_push_s = 1'b0;
    total++;
    if (vcnt != 12 || first != 9 || smax != 2) begin
      bad++;
      $display("FAIL n3 compute len=%0d first=%0d max_stage=%0d want 12 9 2", vcnt, first, smax);
    end
    total++;
    if (dcnt != 8 || frame_cnt_s !== 16'd1) begin
      bad++;
      $display("FAIL n3 drain len=%0d frames=%0d want 8 1", dcnt, frame_cnt_s);
    end
  endtask

  task automatic test_log2n6();
    int first, vcnt, dcnt, smax, bmax;
    first = -1; vcnt = 0; dcnt = 0; smax = 0; bmax = 0;
    do_reset();
    for (int c = 0; c <= 400; c++) begin
      in_push_l = (c < 64);
      if (eng_valid_l === 1'b1) begin
        if (first < 0) first = c;
        vcnt++;
        if (int'(eng_stage_l) > smax) smax = int'(eng_stage_l);
        if (int'(eng_bfly_l) > bmax) bmax = int'(eng_bfly_l);
      end
      if (out_push_l === 1'b1) dcnt++;
      @(negedge clk);
    end
    in_push_l = 1'b0;
    total++;
    if (vcnt != 192 || first != 65 || smax != 5 || bmax != 31) begin
      bad++;
      $display("FAIL n6 compute len=%0d first=%0d max_stage=%0d max_bfly=%0d want 192 65 5 31",
               vcnt, first, smax, bmax);
    end
    total++;
    if (dcnt != 64 || frame_cnt_l !== 16'd1) begin
      bad++;
      $display("FAIL n6 drain len=%0d frames=%0d want 64 1", dcnt, frame_cnt_l);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    do_reset();
    test_single_frame("single");
    test_back_to_back();
    test_out_stall();
    test_overrun();
    test_reset_mid();
    test_log2n3();
    test_log2n6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
